button_debouncer: RTL and testbench

//  Cleans a raw, bouncing push-button input for the LED blink logic that sits

---
 rtl/button_debouncer_if.sv | 24 ++
 rtl/button_debouncer.sv | 131 +++++++++++++
 tb/tb_button_debouncer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button in, debounced level and strobes out.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer, 4-state debounce FSM, press/release strobes.
// Optional long-press strobe when LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input logic             clk,
    input logic             rst_n,
    button_debouncer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    level_q <= 1'b0;
                    if (s) begin
                        state_q <= StPressWait;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StPressWait: begin
                    if (!s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StPressed: begin
                    level_q <= 1'b1;
                    if (!s) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                StReleaseWait: begin
                    if (s) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // Counter parks at LONG_CYCLES so the strobe fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q == StPressed || state_q == StReleaseWait) begin
                if (hold_q != HOLD_W'(LONG_CYCLES)) begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
                if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
                    long_q <= 1'b1;
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign bus.long_pulse = long_q;
`else
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
    assign bus.long_pulse     = 1'b0;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected strobes queued with their edge numbers.
module tb_button_debouncer;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 32;
    localparam int          LAT  = SYNC + DEB - 1;

    typedef struct {
        int kind;    // 1 press, 2 release, 3 long
        int edge_n;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   edges = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    button_debouncer_if bus ();

    button_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edges);
        end
    endtask

    task automatic push_ev(input int kind, input int edge_n);
        ev_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        exp_q.push_back(e);
    endtask

    task automatic handle_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_edge", edges, e.edge_n);
        end
        if (kind == 1) check("lvl_at_press", int'(bus.btn_level), 1);
        if (kind == 2) check("lvl_at_release", int'(bus.btn_level), 0);
    endtask

    always @(negedge clk) begin
        if (bus.press_pulse && bus.release_pulse) check("strobe_excl", 1, 0);
        if (bus.press_pulse) handle_ev(1);
        if (bus.release_pulse) handle_ev(2);
        if (bus.long_pulse) handle_ev(3);
    end

    // Input changes at a falling edge; it is first sampled by the next rising edge.
    task automatic drive(input logic v, output int s_edge);
        @(negedge clk);
        bus.btn_in = v;
        s_edge = edges + 1;
    endtask

    task automatic wait_until(input int n);
        while (edges < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got edge %0d expected finish", edges);
        $fatal(1, "timeout");
    end

    initial begin
        int s_e;
        int r_e;
        logic seq [6];
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // 1. reset with button held, then release reset
        rst_n      = 1'b1;
        bus.btn_in = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_outs", int'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                    bus.long_pulse}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_e = edges + 1;
        push_ev(1, s_e + LAT);
        wait_until(s_e + LAT - 1);
        check("rst_rel_lvl_before", int'(bus.btn_level), 0);
        wait_until(s_e + LAT);
        check("rst_rel_lvl", int'(bus.btn_level), 1);
        drive(1'b0, r_e);
        push_ev(2, r_e + LAT);
        wait_until(r_e + LAT + 3);
        check("rst_rel_lvl_off", int'(bus.btn_level), 0);

        // 2. clean press held 20 cycles
        drive(1'b1, s_e);
        push_ev(1, s_e + LAT);
        wait_until(s_e + LAT - 1);
        check("clean_lvl_before", int'(bus.btn_level), 0);
        wait_until(s_e + LAT);
        check("clean_lvl", int'(bus.btn_level), 1);
        wait_until(s_e + 19);
        drive(1'b0, r_e);
        push_ev(2, r_e + LAT);
        wait_until(r_e + LAT - 1);
        check("clean_rel_before", int'(bus.btn_level), 1);
        wait_until(r_e + LAT);
        check("clean_rel_lvl", int'(bus.btn_level), 0);
        wait_until(r_e + LAT + 3);

        // 3. bounce then settle high
        for (int i = 0; i < 6; i++) begin
            drive(seq[i], s_e);
            check("bounce_lvl", int'(bus.btn_level), 0);
        end
        push_ev(1, s_e + LAT);
        wait_until(s_e + LAT - 1);
        check("bounce_lvl_before", int'(bus.btn_level), 0);
        wait_until(s_e + LAT);
        check("bounce_lvl_after", int'(bus.btn_level), 1);
        drive(1'b0, r_e);
        push_ev(2, r_e + LAT);
        wait_until(r_e + LAT + 3);

        // 4a. 7-sample high glitch while idle
        drive(1'b1, s_e);
        repeat (6) @(negedge clk);
        drive(1'b0, r_e);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("glitch_hi_lvl", int'(bus.btn_level), 0);
        end

        // 4b. 7-sample low glitch while pressed
        drive(1'b1, s_e);
        push_ev(1, s_e + LAT);
        wait_until(s_e + LAT + 2);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.btn_in = 1'b0;
            check("glitch_lo_lvl", int'(bus.btn_level), 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.btn_in = 1'b1;
            check("glitch_lo_lvl", int'(bus.btn_level), 1);
        end
        drive(1'b0, r_e);
        push_ev(2, r_e + LAT);
        wait_until(r_e + LAT + 3);

        // 5. asynchronous reset while pressed
        drive(1'b1, s_e);
        push_ev(1, s_e + LAT);
        wait_until(s_e + LAT + 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lvl", int'(bus.btn_level), 0);
        check("async_rst_rel", int'(bus.release_pulse), 0);
        bus.btn_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) @(negedge clk);
        check("after_rst_lvl", int'(bus.btn_level), 0);

        // 6. long hold of 60 cycles
        drive(1'b1, s_e);
        push_ev(1, s_e + LAT);
`ifdef LONG_PRESS_EN
        push_ev(3, s_e + LAT + LONG);
`endif
        wait_until(s_e + LAT + LONG - 1);
        check("long_before", int'(bus.long_pulse), 0);
        wait_until(s_e + LAT + LONG);
`ifdef LONG_PRESS_EN
        check("long_at", int'(bus.long_pulse), 1);
`else
        check("long_at", int'(bus.long_pulse), 0);
`endif
        wait_until(s_e + LAT + LONG + 1);
        check("long_after", int'(bus.long_pulse), 0);
        wait_until(s_e + 59);
        drive(1'b0, r_e);
        push_ev(2, r_e + LAT);
        wait_until(r_e + LAT + 5);
        check("long_rel_lvl", int'(bus.btn_level), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
